shift_deser: RTL and testbench

- Serial-to-parallel receiver: the receive end of the serial bit stream produced by the team's shift register.
- Waits for a start bit, then captures N data bits MSB-first into a parallel word.
- Presents the word with a valid/ack handshake and flags overrun when a word is lost.
- Sits between a serial link input and word-oriented logic.

---
 rtl/shift_deser_pkg.sv | 14 +
 rtl/shift_deser_sipo_reg.sv | 26 ++
 rtl/shift_deser.sv | 101 ++++++++++
 tb/tb_shift_deser.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/shift_deser_pkg.sv
// Shared state encoding and counter-width helper for the serial deserializer.
package shift_deser_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Bit-count width for an N-bit frame; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/shift_deser_sipo_reg.sv
// N-bit serial-in/parallel-out register, MSB-first, with synchronous clear.
module sipo_reg #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic         din,
  output logic [N-1:0] q
);

  logic [N-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (en) q_d = {q_q[N-2:0], din};
  end

  always_ff @(posedge clk) begin
    if (clr) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/shift_deser.sv
// Serial-to-parallel receiver: start bit, then N data bits MSB-first,
// delivered through a valid/ack handshake with a sticky overrun flag.
module shift_deser
  import shift_deser_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         res,
  input  logic         en,
  input  logic         din,
  input  logic         ack,
  output logic [N-1:0] dout,
  output logic         valid,
  output logic         busy,
  output logic         overrun
);

  localparam int            CW   = cnt_w(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  dout_q, dout_d;
  logic          valid_q, valid_d;
  logic          ovr_q, ovr_d;
  logic [N-1:0]  sr;
  logic          shift_go, done, accept, drop;

  assign shift_go = (state_q == ST_SHIFT) && en;
  assign done     = shift_go && (cnt_q == LAST);
  assign accept   = valid_q && ack;
  assign drop     = done && valid_q && !ack;

  sipo_reg #(.N(N)) u_sr (
    .clk (clk),
    .clr (res),
    .en  (shift_go),
    .din (din),
    .q   (sr)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (en && din) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
        if (done) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (shift_go) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The completing bit goes straight to dout; sr still lags it by one.
    if (done && !drop) begin
      dout_d  = {sr[N-2:0], din};
      valid_d = 1'b1;
    end else if (accept) begin
      valid_d = 1'b0;
    end

    if (drop)        ovr_d = 1'b1;
    else if (accept) ovr_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign dout    = dout_q;
  assign valid   = valid_q;
  assign busy    = (state_q == ST_SHIFT);
  assign overrun = ovr_q;

endmodule

// File: tb/tb_shift_deser.sv
// Directed bench for shift_deser (N=4): reset, framing, pause, overrun, handshake.
module tb_shift_deser;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         res = 1'b1;
  logic         en  = 1'b0;
  logic         din = 1'b0;
  logic         ack = 1'b0;
  logic [N-1:0] dout;
  logic         valid, busy, overrun;

  int checks = 0;
  int failures = 0;

  shift_deser #(.N(N)) dut (
    .clk     (clk),
    .res     (res),
    .en      (en),
    .din     (din),
    .ack     (ack),
    .dout    (dout),
    .valid   (valid),
    .busy    (busy),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  // Apply inputs for one cycle; return 1 time unit after the rising edge.
  task automatic drive(input logic e, input logic d, input logic a);
    en = e; din = d; ack = a;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [N-1:0] w);
    logic [N-1:0] v;
    v = w;
    drive(1'b1, 1'b1, 1'b0);
    for (int i = N - 1; i >= 0; i--) drive(1'b1, v[i], 1'b0);
    en = 1'b0;
  endtask

  task automatic test_reset();
    res = 1'b1;
    for (int i = 0; i < 2; i++) drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    checks++;
    if ({dout, valid, busy, overrun} !== 7'b0000_000) begin
      failures++;
      $display("FAIL reset: dout=%b valid=%b busy=%b overrun=%b, need all 0", dout, valid, busy, overrun);
    end
    res = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_single();
    drive(1'b1, 1'b1, 1'b0);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_start: busy=%b need 1", busy); end
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    checks++;
    if (valid !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL single_pre: valid=%b busy=%b need 0/1", valid, busy);
    end
    drive(1'b1, 1'b1, 1'b0);
    checks++;
    if (valid !== 1'b1 || dout !== 4'b1011 || busy !== 1'b0) begin
      failures++; $display("FAIL single_done: valid=%b dout=%b busy=%b need 1/1011/0", valid, dout, busy);
    end
    drive(1'b0, 1'b0, 1'b1);
    checks++;
    if (valid !== 1'b0 || dout !== 4'b1011) begin
      failures++; $display("FAIL single_ack: valid=%b dout=%b need 0/1011", valid, dout);
    end
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_paused();
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    checks++;
    if (valid !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL paused_hold: valid=%b busy=%b need 0/1", valid, busy);
    end
    drive(1'b1, 1'b1, 1'b0);
    checks++;
    if (valid !== 1'b1 || dout !== 4'b0101) begin
      failures++; $display("FAIL paused_done: valid=%b dout=%b need 1/0101", valid, dout);
    end
    drive(1'b0, 1'b0, 1'b1);
    checks++;
    if (valid !== 1'b0) begin failures++; $display("FAIL paused_ack: valid=%b need 0", valid); end
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_overrun();
    send_frame(4'b1011);
    send_frame(4'b0110);
    checks++;
    if (valid !== 1'b1 || dout !== 4'b1011 || overrun !== 1'b1) begin
      failures++; $display("FAIL overrun_set: valid=%b dout=%b overrun=%b need 1/1011/1", valid, dout, overrun);
    end
    drive(1'b0, 1'b0, 1'b1);
    checks++;
    if (valid !== 1'b0 || overrun !== 1'b0 || dout !== 4'b1011) begin
      failures++; $display("FAIL overrun_clr: valid=%b overrun=%b dout=%b need 0/0/1011", valid, overrun, dout);
    end
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_simul_ack();
    send_frame(4'b1011);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1);
    checks++;
    if (valid !== 1'b1 || dout !== 4'b0110 || overrun !== 1'b0) begin
      failures++; $display("FAIL simul_ack: valid=%b dout=%b overrun=%b need 1/0110/0", valid, dout, overrun);
    end
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    res = 1'b1;
    drive(1'b1, 1'b1, 1'b0);
    res = 1'b0;
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0 || overrun !== 1'b0) begin
      failures++; $display("FAIL midreset: busy=%b valid=%b overrun=%b need 0/0/0", busy, valid, overrun);
    end
    send_frame(4'b1001);
    checks++;
    if (valid !== 1'b1 || dout !== 4'b1001 || overrun !== 1'b0) begin
      failures++; $display("FAIL midreset_frame: valid=%b dout=%b overrun=%b need 1/1001/0", valid, dout, overrun);
    end
  endtask

  task automatic test_back_to_back();
    // Start bit on the cycle right after completion, consuming the pending word.
    drive(1'b1, 1'b1, 1'b1);
    checks++;
    if (busy !== 1'b1 || valid !== 1'b0) begin
      failures++; $display("FAIL b2b_start: busy=%b valid=%b need 1/0", busy, valid);
    end
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    checks++;
    if (valid !== 1'b1 || dout !== 4'b0011 || busy !== 1'b0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL b2b_done: valid=%b dout=%b busy=%b overrun=%b need 1/0011/0/0", valid, dout, busy, overrun);
    end
    drive(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_paused();
    test_overrun();
    test_simul_ack();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
